// File: rtl/rto_dac_spi_master.sv
// SPI mode-0 DAC master fed by RTO timestamp matches.
// Small payload queue, one cs_n frame per word, optional LDAC strobe.
module rto_dac_spi_master #(
   parameter int DATA_WIDTH  = 24,
   parameter int CLK_DIV     = 2,
   parameter int QUEUE_DEPTH = 4,
   parameter int CS_SETUP    = 2,
   parameter int CS_HOLD     = 2,
   parameter int LDAC_WIDTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        matched_valid,
   input  logic [63:0] matched_data,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   output logic        ldac_n,
   output logic        busy,
   output logic        queue_full,
   output logic        frame_done,
   output logic        overflow_error,
   output logic [63:0] overflow_error_data
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam int CW = 16;
   localparam int EW = DATA_WIDTH + 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(QUEUE_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_LDAC
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  half_q, half_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic                  ldac_flag_q, ldac_flag_d;
   logic                  done_d;

   logic [EW-1:0]         mem_q [QUEUE_DEPTH];
   logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]           count_q, count_d;
   logic [EW-1:0]         head;
   logic                  q_empty, q_full, pop, push, drop;

   logic                  sclk_q, cs_n_q, mosi_q, ldac_n_q;
   logic                  busy_q, full_q, done_q, ovf_q;
   logic [63:0]           ovf_data_q;

   assign q_empty = (count_q == '0);
   assign q_full  = (count_q == FULL_CNT);
   assign head    = mem_q[rd_q];
   assign pop     = (state_q == S_IDLE) && !q_empty;
   assign push    = matched_valid && !flush && (!q_full || pop);
   assign drop    = matched_valid && !flush && q_full && !pop;

   // flush drops pointers only; a word popped the same cycle still ships
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push) wr_d = wr_q + AW'(1);
         if (pop)  rd_d = rd_q + AW'(1);
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {matched_data[63], matched_data[DATA_WIDTH-1:0]};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      half_d      = half_q;
      sr_d        = sr_q;
      ldac_flag_d = ldac_flag_q;
      done_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!q_empty) begin
               sr_d        = head[DATA_WIDTH-1:0];
               ldac_flag_d = head[DATA_WIDTH];
               cnt_d       = '0;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == CW'(CS_SETUP-1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               half_d  = 1'b0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SHIFT: begin
            if (cnt_q == CW'(CLK_DIV-1)) begin
               cnt_d = '0;
               if (!half_q) begin
                  half_d = 1'b1;
               end else if (bit_q == BW'(DATA_WIDTH-1)) begin
                  state_d = S_HOLD;
               end else begin
                  half_d = 1'b0;
                  bit_d  = bit_q + BW'(1);
                  sr_d   = {sr_q[DATA_WIDTH-2:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == CW'(CS_HOLD-1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = ldac_flag_q ? S_LDAC : S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_LDAC: begin
            if (cnt_q == CW'(LDAC_WIDTH-1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // outputs are registered from next-state so pins line up with the FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         half_q      <= 1'b0;
         sr_q        <= '0;
         ldac_flag_q <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ldac_n_q    <= 1'b1;
         busy_q      <= 1'b0;
         full_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ovf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         half_q      <= half_d;
         sr_q        <= sr_d;
         ldac_flag_q <= ldac_flag_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         sclk_q      <= (state_d == S_SHIFT) && half_d;
         cs_n_q      <= !((state_d == S_SETUP) || (state_d == S_SHIFT) ||
                          (state_d == S_HOLD));
         mosi_q      <= ((state_d == S_SETUP) || (state_d == S_SHIFT)) &&
                        sr_d[DATA_WIDTH-1];
         ldac_n_q    <= (state_d != S_LDAC);
         busy_q      <= (state_d != S_IDLE) || (count_d != '0);
         full_q      <= (count_d == FULL_CNT);
         done_q      <= done_d;
         ovf_q       <= drop;
         if (drop) ovf_data_q <= matched_data;
      end
   end

   assign sclk                = sclk_q;
   assign cs_n                = cs_n_q;
   assign mosi                = mosi_q;
   assign ldac_n              = ldac_n_q;
   assign busy                = busy_q;
   assign queue_full          = full_q;
   assign frame_done          = done_q;
   assign overflow_error      = ovf_q;
   assign overflow_error_data = ovf_data_q;

endmodule

// File: tb/tb_rto_dac_spi_master.sv
// Randomised scoreboard bench for rto_dac_spi_master.
// Cycle-level queue/server model predicts frames, drops, busy and full.
module tb_rto_dac_spi_master;

   localparam int DW     = 24;
   localparam int DIV    = 2;
   localparam int DEPTH  = 4;
   localparam int SETUP  = 2;
   localparam int HOLD   = 2;
   localparam int LWID   = 2;
   localparam int FRAME  = SETUP + 2*DIV*DW + HOLD;

   typedef struct {
      logic [DW-1:0] w;
      bit            ldac;
      int            start;
   } frame_t;

   logic        clk = 0;
   logic        reset = 0;
   logic        flush = 0;
   logic        matched_valid = 0;
   logic [63:0] matched_data = '0;
   logic        sclk, cs_n, mosi, ldac_n, busy, queue_full;
   logic        frame_done, overflow_error;
   logic [63:0] overflow_error_data;

   rto_dac_spi_master dut (
      .clk                 (clk),
      .reset               (reset),
      .flush               (flush),
      .matched_valid       (matched_valid),
      .matched_data        (matched_data),
      .sclk                (sclk),
      .cs_n                (cs_n),
      .mosi                (mosi),
      .ldac_n              (ldac_n),
      .busy                (busy),
      .queue_full          (queue_full),
      .frame_done          (frame_done),
      .overflow_error      (overflow_error),
      .overflow_error_data (overflow_error_data)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc_cnt);
      end
   endtask

   // reference model: payload queue plus a server busy until free_at
   logic [63:0] mq[$];
   logic [63:0] exp_ovf[$];
   frame_t      exp_frames[$];
   int          free_at = 0;
   bit          exp_busy = 0;
   bit          exp_full = 0;

   task automatic cycle(input bit v, input logic [63:0] d, input bit f);
      frame_t      fr;
      logic [63:0] h;
      chk(busy === exp_busy, "busy", 64'(busy), 64'(exp_busy));
      chk(queue_full === exp_full, "queue_full", 64'(queue_full), 64'(exp_full));
      matched_valid = v;
      matched_data  = d;
      flush         = f;
      if (mq.size() > 0 && cyc_cnt >= free_at) begin
         h        = mq.pop_front();
         fr.w     = h[DW-1:0];
         fr.ldac  = h[63];
         fr.start = cyc_cnt + 1;
         exp_frames.push_back(fr);
         free_at  = cyc_cnt + FRAME + 1 + (fr.ldac ? LWID : 0);
      end
      if (f) mq.delete();
      else if (v) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else exp_ovf.push_back(d);
      end
      exp_busy = (mq.size() > 0) || (cyc_cnt + 1 < free_at);
      exp_full = (mq.size() == DEPTH);
      @(negedge clk);
      matched_valid = 0;
      flush         = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, 0);
   endtask

   // monitor: rebuild frames from the pins and retire expectations
   logic          prev_cs = 1, prev_sclk = 0, prev_ldac = 1;
   logic [DW-1:0] word;
   int            nbits, low_len, f_start, ldac_cnt;
   bit            pending_ldac = 0;
   frame_t        got;
   logic [63:0]   oexp;

   always @(negedge clk) begin
      if (!reset) begin
         prev_cs      = 1;
         prev_sclk    = 0;
         prev_ldac    = 1;
         pending_ldac = 0;
         ldac_cnt     = 0;
         nbits        = 0;
         low_len      = 0;
      end else begin
         chk(frame_done === (cs_n && !prev_cs), "frame_done",
             64'(frame_done), 64'(cs_n && !prev_cs));
         if (!cs_n && prev_cs) begin
            chk(!pending_ldac, "ldac_missing", 64'(pending_ldac), 64'd0);
            pending_ldac = 0;
            word    = '0;
            nbits   = 0;
            low_len = 0;
            f_start = cyc_cnt;
         end
         if (!cs_n) begin
            low_len++;
            if (sclk && !prev_sclk) begin
               word = {word[DW-2:0], mosi};
               nbits++;
            end
         end
         if (cs_n && !prev_cs) begin
            if (exp_frames.size() == 0) begin
               chk(0, "unexpected_frame", 64'(word), 64'd0);
            end else begin
               got = exp_frames.pop_front();
               chk(word === got.w, "frame_word", 64'(word), 64'(got.w));
               chk(nbits == DW, "frame_bits", 64'(nbits), 64'(DW));
               chk(low_len == FRAME, "cs_low_len", 64'(low_len), 64'(FRAME));
               chk(f_start == got.start, "frame_start",
                   64'(f_start), 64'(got.start));
               pending_ldac = got.ldac;
            end
         end
         if (!ldac_n) begin
            ldac_cnt++;
            chk(cs_n === 1'b1, "ldac_cs_n", 64'(cs_n), 64'd1);
         end
         if (ldac_n && !prev_ldac) begin
            chk(pending_ldac, "ldac_unexpected", 64'(pending_ldac), 64'd1);
            chk(ldac_cnt == LWID, "ldac_width", 64'(ldac_cnt), 64'(LWID));
            pending_ldac = 0;
         end
         if (ldac_n) ldac_cnt = 0;
         if (overflow_error) begin
            if (exp_ovf.size() == 0) begin
               chk(0, "unexpected_overflow", overflow_error_data, 64'd0);
            end else begin
               oexp = exp_ovf.pop_front();
               chk(overflow_error_data === oexp, "overflow_data",
                   overflow_error_data, oexp);
            end
         end
         prev_cs   = cs_n;
         prev_sclk = sclk;
         prev_ldac = ldac_n;
      end
   end

   task automatic model_reset();
      mq.delete();
      exp_frames.delete();
      exp_ovf.delete();
      free_at  = 0;
      exp_busy = 0;
      exp_full = 0;
   endtask

   logic [63:0] d6;

   initial begin
      repeat (3) @(negedge clk);
      chk(sclk === 1'b0, "rst_sclk", 64'(sclk), 64'd0);
      chk(cs_n === 1'b1, "rst_cs_n", 64'(cs_n), 64'd1);
      chk(mosi === 1'b0, "rst_mosi", 64'(mosi), 64'd0);
      chk(ldac_n === 1'b1, "rst_ldac_n", 64'(ldac_n), 64'd1);
      chk(frame_done === 1'b0, "rst_done", 64'(frame_done), 64'd0);
      chk(overflow_error === 1'b0, "rst_ovf", 64'(overflow_error), 64'd0);
      chk(overflow_error_data === 64'd0, "rst_ovf_data",
          overflow_error_data, 64'd0);
      reset = 1;

      // single word, then an LDAC word
      idle(2);
      cycle(1, 64'h0000_0000_00A5_F00F, 0);
      idle(110);
      cycle(1, 64'h8000_0000_0000_0001, 0);
      idle(115);

      // five back-to-back pushes while idle
      for (int i = 0; i < 5; i++) cycle(1, {$urandom, $urandom}, 0);
      idle(5 * (FRAME + 1 + LWID) + 10);

      // six pushes behind an in-flight frame: two dropped
      cycle(1, {1'b0, 31'($urandom), $urandom}, 0);
      idle(3);
      for (int i = 0; i < 6; i++) begin
         d6 = {$urandom, $urandom};
         cycle(1, d6, 0);
      end
      chk(overflow_error_data === d6, "ovf_data_last", overflow_error_data, d6);
      idle(5 * (FRAME + 1 + LWID) + 10);

      // flush with three queued words and one in flight
      cycle(1, {$urandom, $urandom}, 0);
      idle(3);
      for (int i = 0; i < 3; i++) cycle(1, {$urandom, $urandom}, 0);
      idle(2);
      cycle(1, {$urandom, $urandom}, 1);
      idle(FRAME + 20);
      chk(busy === 1'b0, "busy_after_flush", 64'(busy), 64'd0);

      // random traffic with occasional flushes
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 29) == 0), {$urandom, $urandom},
               ($urandom_range(0, 299) == 0));
      end
      idle(DEPTH * (FRAME + 1 + LWID) + 120);

      // reset in the middle of bit 10 of a frame
      cycle(1, 64'h0000_0000_00FF_FFFF, 0);
      cycle(1, {$urandom, $urandom}, 0);
      cycle(1, {$urandom, $urandom}, 0);
      idle(42);
      chk(cs_n === 1'b0, "pre_reset_cs_n", 64'(cs_n), 64'd0);
      #1 reset = 0;
      #1;
      chk(cs_n === 1'b1, "mid_rst_cs_n", 64'(cs_n), 64'd1);
      chk(sclk === 1'b0, "mid_rst_sclk", 64'(sclk), 64'd0);
      chk(mosi === 1'b0, "mid_rst_mosi", 64'(mosi), 64'd0);
      chk(busy === 1'b0, "mid_rst_busy", 64'(busy), 64'd0);
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1;
      idle(2 * FRAME + 20);

      chk(exp_frames.size() == 0, "frames_left", 64'(exp_frames.size()), 64'd0);
      chk(exp_ovf.size() == 0, "overflows_left", 64'(exp_ovf.size()), 64'd0);
      chk(!pending_ldac, "ldac_left", 64'(pending_ldac), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
